cla_pipe_adder: RTL

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla_block.sv | 41 ++++
 rtl/cla_pipe_adder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants and stage payload type for the pipelined carry-lookahead adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   CLA_WIDTH / CLA_BLOCK : default operand width and lookahead group size
//   NBLK                  : number of lookahead groups at the default sizes
//   cla_stage_t           : S1 payload (per-bit g/p, per-group G/P, carry-in)
package cla_pkg;

    localparam int CLA_WIDTH = 32;
    localparam int CLA_BLOCK = 8;
    localparam int NBLK      = CLA_WIDTH / CLA_BLOCK;

    // S1 payload at the default sizes. The adder top declares an identically
    // laid-out type sized from its own parameters so non-default widths work.
    typedef struct packed {
        logic [CLA_WIDTH-1:0] g;       // per-bit generate  a & b'
        logic [CLA_WIDTH-1:0] p;       // per-bit propagate a | b'
        logic [NBLK-1:0]      blk_g;   // group generate
        logic [NBLK-1:0]      blk_p;   // group propagate
        logic                 cin;     // carry into group 0
    } cla_stage_t;

endpackage

// File: rtl/cla_block.sv
// One lookahead group: sum bits plus group generate/propagate from per-bit g/p.
// Latency: purely combinational, 0 cycles.
// Backpressure: none (no state, no handshake).
//
// Ports:
//   g, p   : per-bit generate (a&b') and propagate (a|b') for this group
//   cin    : carry into the group's LSB
//   sum    : p ^ g ^ carry per bit (p ^ g equals a ^ b' since p is OR, g is AND)
//   grp_g  : group generate, grp_p : group propagate
module cla_block #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] g,
    input  logic [BLOCK-1:0] p,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             grp_g,
    output logic             grp_p
);

    // Each bit carry is formed as (prefix G) | (prefix P & cin), i.e. from the
    // group carry-in directly rather than from the neighbouring bit's carry.
    always_comb begin
        logic             gacc;
        logic             pacc;
        logic [BLOCK-1:0] c;
        gacc = 1'b0;
        pacc = 1'b1;
        c    = '0;
        sum  = '0;
        for (int i = 0; i < BLOCK; i++) begin
            c[i]   = gacc | (pacc & cin);
            sum[i] = p[i] ^ g[i] ^ c[i];
            gacc   = g[i] | (p[i] & gacc);
            pacc   = pacc & p[i];
        end
        grp_g = gacc;
        grp_p = pacc;
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Latency: result is valid 2 cycles after the accepting cycle; 1 beat/cycle throughput.
// Backpressure: out_ready low freezes S2; in_ready = !S1_valid || S1 can advance.
//
// Ports:
//   clock, reset          : sole clock, synchronous active-high reset
//   in_valid / in_ready   : operand beat handshake (data_a, data_b, sub)
//   out_valid / out_ready : result beat handshake (sum, cout, ovf)
//   sum                   : (a +/- b) mod 2^WIDTH, cout: MSB carry-out, ovf: signed overflow
// Build option: define CLA_SUB_EN to honour sub (A-B); otherwise sub is ignored
// and the block always adds.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NB = WIDTH / BLOCK;

    if ((WIDTH % BLOCK) != 0) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK");
    end

    // Same layout as cla_stage_t, sized from this instance's parameters.
    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [NB-1:0]    blk_g;
        logic [NB-1:0]    blk_p;
        logic             cin;
    } stage_t;

    // ------------------------------------------------------------------
    // Operand conditioning: B' and carry-in
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic             cin_d;

`ifdef CLA_SUB_EN
    // Subtraction as A + ~B + 1: the +1 rides in on the group-0 carry-in.
    assign b_eff = sub ? ~data_b : data_b;
    assign cin_d = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = data_b;
    assign cin_d      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // S1 next-state: per-bit g/p and per-group G/P
    // ------------------------------------------------------------------
    stage_t s1_d;
    stage_t s1_q;
    logic   s1_vld;

    always_comb begin
        logic gacc;
        logic pacc;
        s1_d     = '0;
        gacc     = 1'b0;
        pacc     = 1'b1;
        s1_d.g   = data_a & b_eff;
        s1_d.p   = data_a | b_eff;
        s1_d.cin = cin_d;
        for (int k = 0; k < NB; k++) begin
            gacc = 1'b0;
            pacc = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                gacc = s1_d.g[k*BLOCK+i] | (s1_d.p[k*BLOCK+i] & gacc);
                pacc = pacc & s1_d.p[k*BLOCK+i];
            end
            s1_d.blk_g[k] = gacc;
            s1_d.blk_p[k] = pacc;
        end
    end

    // ------------------------------------------------------------------
    // Handshake: S2 moves when empty or being drained; S1 moves with S2.
    // ------------------------------------------------------------------
    logic s2_vld;
    logic s2_adv;

    assign s2_adv   = !s2_vld || out_ready;
    assign in_ready = !s1_vld || s2_adv;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 next-state: group carry chain, per-group sums, flags
    // ------------------------------------------------------------------
    logic [NB:0]      c;
    logic [WIDTH-1:0] sum_d;
    logic [NB-1:0]    grp_g;
    logic [NB-1:0]    grp_p;
    logic             msb_cin;
    logic             cout_d;
    logic             ovf_d;

    always_comb begin
        c    = '0;
        c[0] = s1_q.cin;
        for (int k = 0; k < NB; k++) begin
            c[k+1] = s1_q.blk_g[k] | (s1_q.blk_p[k] & c[k]);
        end
    end

    for (genvar k = 0; k < NB; k++) begin : g_blk
        cla_block #(
            .BLOCK (BLOCK)
        ) u_blk (
            .g     (s1_q.g[k*BLOCK +: BLOCK]),
            .p     (s1_q.p[k*BLOCK +: BLOCK]),
            .cin   (c[k]),
            .sum   (sum_d[k*BLOCK +: BLOCK]),
            .grp_g (grp_g[k]),
            .grp_p (grp_p[k])
        );
    end

    // sum[msb] = (p^g)[msb] ^ carry_in[msb], so the carry into the MSB falls
    // out of the sum bit without a separate bit-level chain.
    assign msb_cin = sum_d[WIDTH-1] ^ s1_q.p[WIDTH-1] ^ s1_q.g[WIDTH-1];
    assign cout_d  = c[NB];
    assign ovf_d   = msb_cin ^ cout_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_vld <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (s2_adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = s2_vld;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Group G/P registered in S1 must agree with what the group cells derive
    // from the same registered per-bit g/p.
    grp_consistent: assert property (@(posedge clock) disable iff (reset)
        (grp_g == s1_q.blk_g) && (grp_p == s1_q.blk_p));

endmodule
